wb_stage: RTL and testbench

- Writeback-stage pipeline register and write-port driver for the pipelined MIPS CPU. It is the writer side of the register file.
- Captures memory-stage results on each clock edge and drives reg_file's two write ports (W_dstE/W_valE, W_dstM/W_valM).
- Enforces the no-write encoding (dst = 0) and the write-priority rules.
- Counts retired instructions and halts the write path on the first non-AOK status.

---
 rtl/wb_stage_if.sv | 31 +++
 rtl/wb_stage.sv | 117 +++++++++++
 tb/tb_wb_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - memory-to-writeback bundle and write-port outputs of the writeback stage
// The master drives the M-stage results and pipeline controls; the writeback stage is the slave.
interface wb_stage_if #(
  parameter int CNT_W = 32
);
  logic             W_stall;
  logic             W_bubble;
  logic             m_valid;
  logic [1:0]       m_stat;
  logic [4:0]       m_dstE;
  logic [4:0]       m_dstM;
  logic [31:0]      m_valE;
  logic [31:0]      m_valM;
  logic [4:0]       W_dstE;
  logic [4:0]       W_dstM;
  logic [31:0]      W_valE;
  logic [31:0]      W_valM;
  logic [1:0]       W_stat;
  logic             halted;
  logic [CNT_W-1:0] retire_count;

  modport master (
    output W_stall, W_bubble, m_valid, m_stat, m_dstE, m_dstM, m_valE, m_valM,
    input  W_dstE, W_dstM, W_valE, W_valM, W_stat, halted, retire_count
  );

  modport slave (
    input  W_stall, W_bubble, m_valid, m_stat, m_dstE, m_dstM, m_valE, m_valM,
    output W_dstE, W_dstM, W_valE, W_valM, W_stat, halted, retire_count
  );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback pipeline register and register-file write-port driver
// Every W output is a register; the first faulting instruction freezes the write path until reset.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  wb_stage_if.slave wb
);

  localparam logic [1:0] STAT_AOK = 2'd0;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       dste_q, dste_d;
  logic [4:0]       dstm_q, dstm_d;
  logic [31:0]      vale_q, vale_d;
  logic [31:0]      valm_q, valm_d;
  logic [1:0]       stat_q, stat_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_fault;

  assign load_fault = !wb.W_bubble && !wb.W_stall && wb.m_valid && (wb.m_stat != STAT_AOK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      dste_q   <= 5'd0;
      dstm_q   <= 5'd0;
      vale_q   <= 32'd0;
      valm_q   <= 32'd0;
      stat_q   <= STAT_AOK;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dste_q   <= dste_d;
      dstm_q   <= dstm_d;
      vale_q   <= vale_d;
      valm_q   <= valm_d;
      stat_q   <= stat_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (load_fault) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    dste_d   = dste_q;
    dstm_d   = dstm_q;
    vale_d   = vale_q;
    valm_d   = valm_q;
    stat_d   = stat_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (wb.W_bubble || (!wb.W_stall && !wb.m_valid)) begin
          dste_d = 5'd0;
          dstm_d = 5'd0;
          vale_d = 32'd0;
          valm_d = 32'd0;
          stat_d = STAT_AOK;
        end else if (wb.W_stall) begin
          // hold: reg_file simply rewrites the same data
        end else if (wb.m_stat == STAT_AOK) begin
          // same nonzero destination on both ports: load data wins
          dste_d = ((wb.m_dstE == wb.m_dstM) && (wb.m_dstE != 5'd0)) ? 5'd0 : wb.m_dstE;
          dstm_d = wb.m_dstM;
          vale_d = wb.m_valE;
          valm_d = wb.m_valM;
          stat_d = STAT_AOK;
          if (!(&cnt_q)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          dste_d   = 5'd0;
          dstm_d   = 5'd0;
          vale_d   = 32'd0;
          valm_d   = 32'd0;
          stat_d   = wb.m_stat;
          halted_d = 1'b1;
        end
      end
      ST_HALTED: begin
        dste_d   = 5'd0;
        dstm_d   = 5'd0;
        halted_d = 1'b1;
      end
      default: begin
        dste_d = 5'd0;
        dstm_d = 5'd0;
      end
    endcase
  end

  assign wb.W_dstE       = dste_q;
  assign wb.W_dstM       = dstm_q;
  assign wb.W_valE       = vale_q;
  assign wb.W_valM       = valm_q;
  assign wb.W_stat       = stat_q;
  assign wb.halted       = halted_q;
  assign wb.retire_count = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage with a 32-bit and a 3-bit retire counter
// Both DUTs see identical stimulus; a monitor checks outputs one cycle after each vector.
module tb_wb_stage;

  logic clk;
  logic reset;

  wb_stage_if #(.CNT_W(32)) ifa ();
  wb_stage_if #(.CNT_W(3))  ifb ();

  wb_stage #(.CNT_W(32)) u_dut_a (.clk(clk), .reset(reset), .wb(ifa));
  wb_stage #(.CNT_W(3))  u_dut_b (.clk(clk), .reset(reset), .wb(ifb));

  typedef struct {
    logic [4:0]  dste;
    logic [4:0]  dstm;
    logic [31:0] vale;
    logic [31:0] valm;
    logic [1:0]  stat;
    logic        halt;
    logic [31:0] cnt;
    logic [31:0] cnt3;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  logic [31:0] rf[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reg_file model written from DUT A's ports; port M lands last so it wins
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      if (ifa.W_dstE != 5'd0) rf[ifa.W_dstE] <= ifa.W_valE;
      if (ifa.W_dstM != 5'd0) rf[ifa.W_dstM] <= ifa.W_valM;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step(input logic rst, input logic stall, input logic bubble, input logic valid,
                      input logic [1:0] stat, input logic [4:0] de, input logic [4:0] dm,
                      input logic [31:0] ve, input logic [31:0] vm,
                      input logic [4:0] e_de, input logic [4:0] e_dm,
                      input logic [31:0] e_ve, input logic [31:0] e_vm,
                      input logic [1:0] e_st, input logic e_h,
                      input logic [31:0] e_c, input logic [31:0] e_c3);
    exp_t e;
    reset        = rst;
    ifa.W_stall  = stall;  ifb.W_stall  = stall;
    ifa.W_bubble = bubble; ifb.W_bubble = bubble;
    ifa.m_valid  = valid;  ifb.m_valid  = valid;
    ifa.m_stat   = stat;   ifb.m_stat   = stat;
    ifa.m_dstE   = de;     ifb.m_dstE   = de;
    ifa.m_dstM   = dm;     ifb.m_dstM   = dm;
    ifa.m_valE   = ve;     ifb.m_valE   = ve;
    ifa.m_valM   = vm;     ifb.m_valM   = vm;
    e.dste = e_de; e.dstm = e_dm; e.vale = e_ve; e.valm = e_vm;
    e.stat = e_st; e.halt = e_h;  e.cnt  = e_c;  e.cnt3 = e_c3;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("W_dstE",       {27'd0, ifa.W_dstE},   {27'd0, e.dste});
        chk("W_dstM",       {27'd0, ifa.W_dstM},   {27'd0, e.dstm});
        chk("W_valE",       ifa.W_valE,            e.vale);
        chk("W_valM",       ifa.W_valM,            e.valm);
        chk("W_stat",       {30'd0, ifa.W_stat},   {30'd0, e.stat});
        chk("halted",       {31'd0, ifa.halted},   {31'd0, e.halt});
        chk("retire_count", ifa.retire_count,      e.cnt);
        chk("W_dstE_b",     {27'd0, ifb.W_dstE},   {27'd0, e.dste});
        chk("W_dstM_b",     {27'd0, ifb.W_dstM},   {27'd0, e.dstm});
        chk("retire_cnt3",  {29'd0, ifb.retire_count}, e.cnt3);
      end
    end
  end

  initial begin : driver
    n_cmp = 0;
    n_bad = 0;
    //   rst st bu va stat de  dm  ve     vm      e_de e_dm e_ve   e_vm  st h cnt c3
    step(1, 0, 0, 0, 2'd0, 0,  0,  32'd0, 32'd0,  0,   0,   32'd0, 32'd0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 2'd0, 0,  0,  32'd0, 32'd0,  0,   0,   32'd0, 32'd0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2'd0, 1,  2,  32'd3, 32'd4,  1,   2,   32'd3, 32'd4, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 1, 2'd0, 5, 0, 32'd9, 32'd0,  1,   2,   32'd3, 32'd4, 0, 0, 1, 1);
    step(0, 1, 1, 1, 2'd0, 5,  0,  32'd9, 32'd0,  0,   0,   32'd0, 32'd0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 2'd0, 7,  7,  32'd10, 32'd20, 0,  7,   32'd10, 32'd20, 0, 0, 2, 2);
    step(0, 0, 0, 0, 2'd0, 4,  0,  32'd11, 32'd0, 0,   0,   32'd0, 32'd0, 0, 0, 2, 2);
    step(0, 0, 0, 1, 2'd0, 0,  0,  32'd5, 32'd0,  0,   0,   32'd5, 32'd0, 0, 0, 3, 3);
    step(0, 0, 0, 1, 2'd2, 3,  0,  32'd6, 32'd0,  0,   0,   32'd0, 32'd0, 2, 1, 3, 3);
    step(0, 1, 1, 1, 2'd0, 3,  0,  32'd8, 32'd0,  0,   0,   32'd0, 32'd0, 2, 1, 3, 3);
    step(0, 0, 0, 1, 2'd0, 3,  0,  32'd8, 32'd0,  0,   0,   32'd0, 32'd0, 2, 1, 3, 3);
    step(0, 0, 0, 1, 2'd0, 3,  3,  32'd8, 32'd8,  0,   0,   32'd0, 32'd0, 2, 1, 3, 3);
    chk("rf_r1", rf[1], 32'd3);
    chk("rf_r2", rf[2], 32'd4);
    chk("rf_r7", rf[7], 32'd20);
    chk("rf_r0", rf[0], 32'd0);
    chk("rf_r3", rf[3], 32'd0);
    chk("rf_r5", rf[5], 32'd0);
    step(1, 0, 0, 1, 2'd0, 3,  0,  32'd8, 32'd0,  0,   0,   32'd0, 32'd0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++)
      step(0, 0, 0, 1, 2'd0, 1, 0, k, 32'd0,   1,   0,   k,     32'd0, 0, 0, k, (k > 7) ? 7 : k);
    step(0, 0, 0, 0, 2'd0, 0,  0,  32'd0, 32'd0,  0,   0,   32'd0, 32'd0, 0, 0, 9, 7);
    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
